// File: rtl/flag_burst_collector.sv
// Summarises each flag-high burst (len, mod sum, first/last, trunc) into a FIFO; PATTERN_CHECK_EN adds out_match.
// Summary visible one cycle after the PUSH state; full FIFO drops summaries (overflow/drop_cnt), never stalls input.
module flag_burst_collector #(
    parameter int DATA_W     = 8,
    parameter int MAX_LEN    = 8,
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 4
`ifdef PATTERN_CHECK_EN
    ,
    parameter logic [DATA_W-1:0] PAT0 = 7,
    parameter logic [DATA_W-1:0] PAT1 = 2,
    parameter logic [DATA_W-1:0] PAT2 = 5
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_flag,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LEN_W-1:0]  out_len,
    output logic [DATA_W-1:0] out_sum,
    output logic [DATA_W-1:0] out_first,
    output logic [DATA_W-1:0] out_last,
    output logic              out_trunc,
    output logic              out_match,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PUSH} state_t;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] first;
        logic [DATA_W-1:0] last;
        logic              trunc;
`ifdef PATTERN_CHECK_EN
        logic              match;
`endif
    } summ_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_init;
    logic              w_accum;
    logic              w_push;

    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] r_first;
    logic [DATA_W-1:0] r_last;
    logic              r_trunc;

    summ_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    summ_t             w_entry;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;
    logic              w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:    w_next = in_flag ? S_COLLECT : S_IDLE;
            S_COLLECT: w_next = in_flag ? S_COLLECT : S_PUSH;
            S_PUSH:    w_next = in_flag ? S_COLLECT : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_init  = in_flag && (r_state != S_COLLECT);
        w_accum = in_flag && (r_state == S_COLLECT);
        w_push  = (r_state == S_PUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= '0;
            r_sum   <= '0;
            r_first <= '0;
            r_last  <= '0;
            r_trunc <= 1'b0;
        end else if (w_init) begin
            r_len   <= LEN_W'(1);
            r_sum   <= in_data;
            r_first <= in_data;
            r_last  <= in_data;
            r_trunc <= 1'b0;
        end else if (w_accum) begin
            if (r_len < LEN_W'(MAX_LEN)) begin
                r_len  <= r_len + 1'b1;
                r_sum  <= r_sum + in_data;
                r_last <= in_data;
            end else begin
                r_trunc <= 1'b1;
            end
        end
    end

`ifdef PATTERN_CHECK_EN
    // Running "prefix matches PAT0..PAT2"; anything past the third byte clears it.
    logic r_pat_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat_ok <= 1'b0;
        end else if (w_init) begin
            r_pat_ok <= (in_data == PAT0);
        end else if (w_accum && (r_len < LEN_W'(MAX_LEN))) begin
            r_pat_ok <= r_pat_ok &&
                        (((r_len == LEN_W'(1)) && (in_data == PAT1)) ||
                         ((r_len == LEN_W'(2)) && (in_data == PAT2)));
        end
    end
`endif

    always_comb begin
        w_entry       = '0;
        w_entry.len   = r_len;
        w_entry.sum   = r_sum;
        w_entry.first = r_first;
        w_entry.last  = r_last;
        w_entry.trunc = r_trunc;
`ifdef PATTERN_CHECK_EN
        w_entry.match = r_pat_ok && (r_len == LEN_W'(3)) && !r_trunc;
`endif
    end

    // A full FIFO still accepts the summary when the head leaves in the same cycle.
    assign out_valid = (r_count != '0);
    assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop     = out_valid && out_ready;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && !w_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign out_len   = r_mem[r_rd_ptr].len;
    assign out_sum   = r_mem[r_rd_ptr].sum;
    assign out_first = r_mem[r_rd_ptr].first;
    assign out_last  = r_mem[r_rd_ptr].last;
    assign out_trunc = r_mem[r_rd_ptr].trunc;
`ifdef PATTERN_CHECK_EN
    assign out_match = r_mem[r_rd_ptr].match;
`else
    assign out_match = 1'b0;
`endif
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_flag_burst_collector.sv
// Scoreboard bench for flag_burst_collector: expected summaries queued at stimulus time, compared on each pop.
module tb_flag_burst_collector;

    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_flag = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [LEN_W-1:0]  out_len;
    logic [DATA_W-1:0] out_sum;
    logic [DATA_W-1:0] out_first;
    logic [DATA_W-1:0] out_last;
    logic              out_trunc;
    logic              out_match;
    logic              overflow;
    logic [7:0]        drop_cnt;

    flag_burst_collector #(
        .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .in_flag(in_flag), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_len(out_len),
        .out_sum(out_sum), .out_first(out_first), .out_last(out_last),
        .out_trunc(out_trunc), .out_match(out_match),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int sum;
        int first;
        int last;
        int trunc;
        int match;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] bb [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic f, input logic [7:0] d, input logic r);
        in_flag   = f;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Reference summary of the first n bytes in bb.
    task automatic model_push(input int n);
        exp_t       e;
        int         l;
        logic [7:0] s;
        l = (n > MAX_LEN) ? MAX_LEN : n;
        s = 8'd0;
        for (int i = 0; i < l; i++) s = s + bb[i];
        e.len   = l;
        e.sum   = int'(s);
        e.first = int'(bb[0]);
        e.last  = int'(bb[l-1]);
        e.trunc = (n > MAX_LEN) ? 1 : 0;
`ifdef PATTERN_CHECK_EN
        e.match = (n == 3 && bb[0] == 8'd7 && bb[1] == 8'd2 && bb[2] == 8'd5) ? 1 : 0;
`else
        e.match = 0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic burst(input int n, input bit accept, input logic r);
        for (int i = 0; i < n; i++) drive(1'b1, bb[i], r);
        drive(1'b0, 8'd0, r);
        if (accept) model_push(n);
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (sb_q.size() == 0 && !out_valid) break;
            drive(1'b0, 8'd0, 1'b1);
        end
        chk("drain_sb_empty", sb_q.size(), 0);
        chk("drain_valid_low", out_valid, 0);
    endtask

    // A pop happens at the next rising edge whenever valid&ready is seen here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pop", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_len",   out_len,   mon_e.len);
                chk("sb_sum",   out_sum,   mon_e.sum);
                chk("sb_first", out_first, mon_e.first);
                chk("sb_last",  out_last,  mon_e.last);
                chk("sb_trunc", out_trunc, mon_e.trunc);
                chk("sb_match", out_match, mon_e.match);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=%0d exp=0", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_valid"},    out_valid, 0);
        chk({pfx, "_len"},      out_len,   0);
        chk({pfx, "_sum"},      out_sum,   0);
        chk({pfx, "_first"},    out_first, 0);
        chk({pfx, "_last"},     out_last,  0);
        chk({pfx, "_trunc"},    out_trunc, 0);
        chk({pfx, "_match"},    out_match, 0);
        chk({pfx, "_overflow"}, overflow,  0);
        chk({pfx, "_drop_cnt"}, drop_cnt,  0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        drive(1'b0, 8'd0, 1'b0);

        // 1: pattern burst, latency of out_valid
        bb[0] = 8'd7; bb[1] = 8'd2; bb[2] = 8'd5;
        burst(3, 1'b1, 1'b1);
        chk("t1_valid_edge_n", out_valid, 0);
        drive(1'b0, 8'd0, 1'b1);
        chk("t1_valid_edge_n1", out_valid, 1);
        drive(1'b0, 8'd0, 1'b1);
        chk("t1_valid_after_pop", out_valid, 0);
        chk("t1_sb_empty", sb_q.size(), 0);

        // 2: six bursts into a stalled consumer, last two dropped
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 3; j++) bb[j] = 8'(k * 10 + j + 1);
            burst(3, k < 4, 1'b0);
        end
        drive(1'b0, 8'd0, 1'b0);
        chk("t2_drop_cnt", drop_cnt, 2);
        chk("t2_overflow", overflow, 1);
        chk("t2_valid_held", out_valid, 1);
        chk("t2_head_first", out_first, 1);
        drive(1'b0, 8'd0, 1'b0);
        chk("t2_head_hold_sum", out_sum, 6);
        drain(20);
        chk("t2_overflow_sticky", overflow, 1);
        chk("t2_drop_cnt_after", drop_cnt, 2);

        // 5: reset in the middle of a burst
        drive(1'b1, 8'd7, 1'b1);
        drive(1'b1, 8'd2, 1'b1);
        in_flag = 1'b0;
        rst     = 1'b1;
        #1;
        check_all_zero("t5_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) drive(1'b0, 8'd0, 1'b1);
        chk("t5_no_partial", out_valid, 0);
        bb[0] = 8'd7; bb[1] = 8'd2; bb[2] = 8'd5;
        burst(3, 1'b1, 1'b1);
        drain(10);

        // 3: truncated 10-byte burst
        for (int j = 0; j < 10; j++) bb[j] = 8'(j + 1);
        burst(10, 1'b1, 1'b1);
        drain(10);

        // 4: PUSH into a full FIFO with a pop in the same cycle
        for (int k = 0; k < 4; k++) begin
            bb[0] = 8'(100 + k);
            burst(1, 1'b1, 1'b0);
        end
        drive(1'b1, 8'd1, 1'b0);
        drive(1'b1, 8'd2, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        bb[0] = 8'd1; bb[1] = 8'd2;
        model_push(2);
        drive(1'b1, 8'd3, 1'b1);
        drive(1'b0, 8'd0, 1'b0);
        bb[0] = 8'd3;
        model_push(1);
        drive(1'b0, 8'd0, 1'b1);
        chk("t4_still_full_valid", out_valid, 1);
        drain(30);
        chk("t4_drop_cnt", drop_cnt, 0);
        chk("t4_overflow", overflow, 0);

        // 6: modulo sum
        bb[0] = 8'd200; bb[1] = 8'd100;
        burst(2, 1'b1, 1'b1);
        drain(10);

        chk("final_sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
